// File: rtl/pipe_pkg.sv
// Shared types and per-stage bundle widths for the generic pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Bundle widths per stage boundary, so every instantiation of a given boundary agrees.
  localparam int IF_ID_CTRL_W  = 8;
  localparam int IF_ID_DATA_W  = 96;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int ID_EX_DATA_W  = 160;
  localparam int EX_MEM_CTRL_W = 8;
  localparam int EX_MEM_DATA_W = 104;
  localparam int MEM_WB_CTRL_W = 4;
  localparam int MEM_WB_DATA_W = 69;
  localparam int PIPE_CNT_W    = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and holds at all-ones.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional 2-entry skid buffer,
// flush-to-bubble and saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_t       state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic              in_xfer, out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid & in_ready & ~flush_i;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (flush_i) begin
      // Data is left stale; only the control bundle must become a bubble.
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d  = ONE;
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end else if (in_xfer) begin
            state_d  = TWO;
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d  = ONE;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q, in_ready_d;
      // Registered ready: the skid register absorbs the entry in flight when downstream stalls.
      assign in_ready_d = (state_d != TWO);
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end
      assign in_ready = in_ready_q;
    end else begin : g_no_skid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  assign out_ctrl = out_valid ? m_ctrl_q : '0;
  assign out_data = m_data_q;

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~out_valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1, SKID=0 and a CNT_W=4 instance share one stimulus stream
// and are checked against queue-based reference models.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst_n, flush_i, in_valid, out_ready;
  logic [15:0]  in_ctrl;
  logic [159:0] in_data;

  logic         in_ready1, out_valid1, in_ready0, out_valid0, in_ready_s, out_valid_s;
  logic [15:0]  out_ctrl1, out_ctrl0, out_ctrl_s, stall1_o, bubble1_o, stall0_o, bubble0_o;
  logic [159:0] out_data1, out_data0, out_data_s;
  logic [3:0]   stall_s, bubble_s;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .stall_cnt(stall1_o), .bubble_cnt(bubble1_o));

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .stall_cnt(stall0_o), .bubble_cnt(bubble0_o));

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_ctrl(out_ctrl_s), .out_data(out_data_s), .stall_cnt(stall_s), .bubble_cnt(bubble_s));

  // Reference model: a FIFO of capacity 2 (SKID=1, ready = not full, registered) or
  // capacity 1 (SKID=0, ready = empty or draining), plus unbounded event counts.
  typedef struct packed {
    logic [15:0]  c;
    logic [159:0] d;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];
  bit   rdy1_m = 1'b1;
  int   stall1 = 0, bub1 = 0, stall0 = 0, bub0 = 0;

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  task automatic model_edge();
    bit   ox1, ix1, ox0, ix0;
    ent_t e;
    if (!rst_n) begin
      q1.delete();
      q0.delete();
      rdy1_m = 1'b1;
      stall1 = 0; bub1 = 0; stall0 = 0; bub0 = 0;
      return;
    end
    if (q1.size() > 0 && !out_ready) stall1++;
    if (q1.size() == 0) bub1++;
    if (q0.size() > 0 && !out_ready) stall0++;
    if (q0.size() == 0) bub0++;
    ox1 = (q1.size() > 0) && out_ready;
    ix1 = in_valid && rdy1_m && !flush_i;
    ox0 = (q0.size() > 0) && out_ready;
    ix0 = in_valid && (q0.size() == 0 || out_ready) && !flush_i;
    e.c = in_ctrl;
    e.d = in_data;
    if (flush_i) begin
      q1.delete();
      q0.delete();
    end else begin
      if (ox1) void'(q1.pop_front());
      if (ix1) q1.push_back(e);
      if (ox0) void'(q0.pop_front());
      if (ix0) q0.push_back(e);
    end
    rdy1_m = (q1.size() < 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [159:0] rnd_data();
    logic [159:0] v;
    for (int k = 0; k < 5; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; in_valid = 1'b1; in_ctrl = 16'hFFFF;
    in_data = rnd_data(); out_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (out_valid1 !== 1'b0) $display("FAIL reset_out_valid1 got=%0b exp=0", out_valid1); else passes++;
    checks++; if (out_ctrl1 !== 16'h0) $display("FAIL reset_out_ctrl1 got=%h exp=0000", out_ctrl1); else passes++;
    checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid0 got=%0b exp=0", out_valid0); else passes++;
    checks++; if (out_ctrl0 !== 16'h0) $display("FAIL reset_out_ctrl0 got=%h exp=0000", out_ctrl0); else passes++;
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (in_ready1 !== 1'b1) $display("FAIL reset_in_ready1 got=%0b exp=1", in_ready1); else passes++;
    checks++; if (in_ready_s !== 1'b1) $display("FAIL reset_in_ready_s got=%0b exp=1", in_ready_s); else passes++;
    checks++; if (out_data1 !== 160'h0) $display("FAIL reset_out_data1 got=%h exp=0", out_data1); else passes++;
    checks++; if (stall1_o !== 16'h0) $display("FAIL reset_stall1 got=%0d exp=0", stall1_o); else passes++;
    checks++; if (bubble1_o !== 16'h0) $display("FAIL reset_bubble1 got=%0d exp=0", bubble1_o); else passes++;
    checks++; if (bubble_s !== 4'h0) $display("FAIL reset_bubble_s got=%0d exp=0", bubble_s); else passes++;
    $display("reset: done");
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (bubble_s !== sat4(i)) $display("FAIL sat_bubble cyc=%0d got=%0d exp=%0d", i, bubble_s, sat4(i)); else passes++;
      tick();
    end
    #1;
    checks++; if (bubble_s !== 4'hF) $display("FAIL sat_hold got=%0d exp=15", bubble_s); else passes++;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    checks++; if (bubble_s !== 4'hF) $display("FAIL sat_after_flush got=%0d exp=15", bubble_s); else passes++;
    checks++; if (bubble1_o !== 16'(bub1)) $display("FAIL bubble1_after_flush got=%0d exp=%0d", bubble1_o, bub1); else passes++;
    $display("saturation: bubble_s=%0d", bubble_s);
  endtask

  task automatic test_streaming();
    logic [159:0] sent [1:8];
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) begin
        in_valid = 1'b1; in_ctrl = 16'(i); sent[i] = rnd_data(); in_data = sent[i];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 1) begin
        checks++; if (out_valid1 !== 1'b1 || out_ctrl1 !== 16'(i-1))
          $display("FAIL stream_ctrl1 idx=%0d got=%0b/%h exp=1/%h", i-1, out_valid1, out_ctrl1, 16'(i-1)); else passes++;
        checks++; if (out_data1 !== sent[i-1]) $display("FAIL stream_data1 idx=%0d got=%h exp=%h", i-1, out_data1, sent[i-1]); else passes++;
        checks++; if (out_valid0 !== 1'b1 || out_ctrl0 !== 16'(i-1))
          $display("FAIL stream_ctrl0 idx=%0d got=%0b/%h exp=1/%h", i-1, out_valid0, out_ctrl0, 16'(i-1)); else passes++;
      end
      tick();
    end
    #1;
    checks++; if (out_valid1 !== 1'b0) $display("FAIL stream_drained got=%0b exp=0", out_valid1); else passes++;
    checks++; if (stall1_o !== 16'h0) $display("FAIL stream_stall got=%0d exp=0", stall1_o); else passes++;
    $display("streaming: 8 entries");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 16'h00A1; in_data = rnd_data();
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h00B2; in_data = rnd_data();
    #1;
    checks++; if (in_ready1 !== 1'b1) $display("FAIL bp_ready_one got=%0b exp=1", in_ready1); else passes++;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (in_ready1 !== 1'b0) $display("FAIL bp_ready_two got=%0b exp=0", in_ready1); else passes++;
      checks++; if (out_valid1 !== 1'b1 || out_ctrl1 !== 16'h00A1)
        $display("FAIL bp_hold_a got=%0b/%h exp=1/00a1", out_valid1, out_ctrl1); else passes++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (out_ctrl1 !== 16'h00A1) $display("FAIL bp_emit_a got=%h exp=00a1", out_ctrl1); else passes++;
    checks++; if (stall1_o !== 16'd3) $display("FAIL bp_stall got=%0d exp=3", stall1_o); else passes++;
    tick();
    #1;
    checks++; if (out_valid1 !== 1'b1 || out_ctrl1 !== 16'h00B2)
      $display("FAIL bp_emit_b got=%0b/%h exp=1/00b2", out_valid1, out_ctrl1); else passes++;
    checks++; if (in_ready1 !== 1'b1) $display("FAIL bp_ready_back got=%0b exp=1", in_ready1); else passes++;
    tick();
    #1;
    checks++; if (out_valid1 !== 1'b0) $display("FAIL bp_drained got=%0b exp=0", out_valid1); else passes++;
    checks++; if (stall1_o !== 16'd3) $display("FAIL bp_stall_final got=%0d exp=3", stall1_o); else passes++;
    $display("backpressure: stall=%0d", stall1_o);
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h00C1; in_data = rnd_data();
    tick();
    in_ctrl = 16'h00C2; in_data = rnd_data();
    tick();
    flush_i = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0055; in_data = rnd_data();
    #1;
    checks++; if (in_ready1 !== 1'b0) $display("FAIL flush_pre_two got=%0b exp=0", in_ready1); else passes++;
    tick();
    flush_i = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid1 !== 1'b0) $display("FAIL flush_valid1 got=%0b exp=0", out_valid1); else passes++;
    checks++; if (out_ctrl1 !== 16'h0) $display("FAIL flush_ctrl1 got=%h exp=0000", out_ctrl1); else passes++;
    checks++; if (in_ready1 !== 1'b1) $display("FAIL flush_ready1 got=%0b exp=1", in_ready1); else passes++;
    checks++; if (out_valid0 !== 1'b0) $display("FAIL flush_valid0 got=%0b exp=0", out_valid0); else passes++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++; if (out_valid1 !== 1'b0 || out_ctrl1 === 16'h0055)
        $display("FAIL flush_no_ghost got=%0b/%h exp=0/0000", out_valid1, out_ctrl1); else passes++;
    end
    $display("flush: killed entries");
  endtask

  task automatic test_skid0();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h00D1; in_data = rnd_data();
    #1;
    checks++; if (in_ready0 !== 1'b1) $display("FAIL s0_ready_empty got=%0b exp=1", in_ready0); else passes++;
    tick();
    in_ctrl = 16'h00D2;
    #1;
    checks++; if (in_ready0 !== 1'b0) $display("FAIL s0_ready_stall got=%0b exp=0", in_ready0); else passes++;
    checks++; if (out_ctrl0 !== 16'h00D1) $display("FAIL s0_hold got=%h exp=00d1", out_ctrl0); else passes++;
    tick();
    in_ctrl = 16'h00D3; out_ready = 1'b1;
    #1;
    checks++; if (out_ctrl0 !== 16'h00D1) $display("FAIL s0_no_accept got=%h exp=00d1", out_ctrl0); else passes++;
    checks++; if (in_ready0 !== 1'b1) $display("FAIL s0_ready_drain got=%0b exp=1", in_ready0); else passes++;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid0 !== 1'b1 || out_ctrl0 !== 16'h00D3)
      $display("FAIL s0_replaced got=%0b/%h exp=1/00d3", out_valid0, out_ctrl0); else passes++;
    tick();
    tick();
    $display("skid0: same-cycle ready ok");
  endtask

  task automatic test_random();
    logic [15:0]  e_c1, e_c0;
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      flush_i   = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = 16'($urandom);
      in_data   = rnd_data();
      #1;
      e_c1 = (q1.size() > 0) ? q1[0].c : 16'h0;
      e_c0 = (q0.size() > 0) ? q0[0].c : 16'h0;
      checks++; if (out_valid1 !== (q1.size() > 0) || out_ctrl1 !== e_c1)
        $display("FAIL rnd_out1 cyc=%0d got=%0b/%h exp=%0b/%h", i, out_valid1, out_ctrl1, q1.size() > 0, e_c1); else passes++;
      if (q1.size() > 0) begin
        checks++; if (out_data1 !== q1[0].d) $display("FAIL rnd_data1 cyc=%0d got=%h exp=%h", i, out_data1, q1[0].d); else passes++;
      end
      checks++; if (in_ready1 !== rdy1_m) $display("FAIL rnd_ready1 cyc=%0d got=%0b exp=%0b", i, in_ready1, rdy1_m); else passes++;
      checks++; if (out_valid0 !== (q0.size() > 0) || out_ctrl0 !== e_c0)
        $display("FAIL rnd_out0 cyc=%0d got=%0b/%h exp=%0b/%h", i, out_valid0, out_ctrl0, q0.size() > 0, e_c0); else passes++;
      checks++; if (in_ready0 !== (q0.size() == 0 || out_ready))
        $display("FAIL rnd_ready0 cyc=%0d got=%0b exp=%0b", i, in_ready0, q0.size() == 0 || out_ready); else passes++;
      checks++; if (stall1_o !== 16'(stall1) || bubble1_o !== 16'(bub1))
        $display("FAIL rnd_cnt1 cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall1_o, bubble1_o, stall1, bub1); else passes++;
      checks++; if (stall0_o !== 16'(stall0) || bubble0_o !== 16'(bub0))
        $display("FAIL rnd_cnt0 cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall0_o, bubble0_o, stall0, bub0); else passes++;
      checks++; if (stall_s !== sat4(stall1) || bubble_s !== sat4(bub1))
        $display("FAIL rnd_cnt_sat cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall_s, bubble_s, sat4(stall1), sat4(bub1)); else passes++;
      tick();
    end
    rst_n = 1'b1; flush_i = 1'b0; in_valid = 1'b0;
    $display("random: 600 cycles");
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
